// File: rtl/chacha20_pkg.sv
// ChaCha20 stream controller: shared sizes, state encoding
// and the byte-count clamp used on block capture.
package chacha20_pkg;

  localparam int BLOCK_BITS  = 512;
  localparam int BLOCK_BYTES = 64;
  localparam int KEY_BITS    = 256;
  localparam int NONCE_BITS  = 96;
  localparam int CTR_BITS    = 32;
  localparam int CNT_BITS    = 7;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ARMED = 3'd1;
  localparam state_t ST_KICK  = 3'd2;
  localparam state_t ST_WAIT  = 3'd3;
  localparam state_t ST_EMIT  = 3'd4;
  localparam state_t ST_ERR   = 3'd5;

  // 0 and anything above a full block mean "full block"
  function automatic logic [CNT_BITS-1:0] clamp_bytes(
    input logic [CNT_BITS-1:0] n
  );
    logic [CNT_BITS-1:0] full;
    full = CNT_BITS'(BLOCK_BYTES);
    return (n == '0 || n > full) ? full : n;
  endfunction

endpackage

// File: rtl/chacha20_byte_mask.sv
// Zeroes every byte of a block at or above the valid count.
// Byte k lives at [8k+7:8k].
module chacha20_byte_mask
  import chacha20_pkg::*;
(
  input  logic [BLOCK_BITS-1:0] data,
  input  logic [CNT_BITS-1:0]   count,
  output logic [BLOCK_BITS-1:0] masked
);

  always_comb begin
    masked = '0;
    for (int k = 0; k < BLOCK_BYTES; k++) begin
      if (CNT_BITS'(k) < count)
        masked[8*k +: 8] = data[8*k +: 8];
    end
  end

endmodule

// File: rtl/chacha20_stream_ctrl.sv
// Sequences a ChaCha20 core over a multi-block message:
// one block in flight, counter per block, masked last block.
module chacha20_stream_ctrl
  import chacha20_pkg::*;
#(
  parameter int CORE_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [KEY_BITS-1:0]   cfg_key,
  input  logic [NONCE_BITS-1:0] cfg_nonce,
  input  logic [CTR_BITS-1:0]   cfg_counter,
  input  logic                  err_clr,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [BLOCK_BITS-1:0] s_data,
  input  logic [CNT_BITS-1:0]   s_bytes,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [BLOCK_BITS-1:0] m_data,
  output logic [CNT_BITS-1:0]   m_bytes,
  output logic                  m_last,
  output logic                  core_start,
  input  logic                  core_busy,
  input  logic                  core_done,
  output logic [KEY_BITS-1:0]   core_key,
  output logic [NONCE_BITS-1:0] core_nonce,
  output logic [CTR_BITS-1:0]   core_counter,
  output logic [BLOCK_BITS-1:0] core_state_in,
  input  logic [BLOCK_BITS-1:0] core_state_out,
  output logic                  busy,
  output logic                  err_ctr_wrap,
  output logic                  err_timeout,
  output logic [31:0]           blk_count
);

  localparam int TW = $clog2(CORE_TIMEOUT) + 1;

  state_t state, state_nx;

  logic [KEY_BITS-1:0]   key_r;
  logic [NONCE_BITS-1:0] nonce_r;
  logic [CTR_BITS-1:0]   ctr_r;
  logic [BLOCK_BITS-1:0] data_r;
  logic [CNT_BITS-1:0]   bytes_r;
  logic                  last_r;
  logic [TW-1:0]         tcount;
  logic [BLOCK_BITS-1:0] masked;
  logic                  timeout;
  logic                  ctr_max;

  // start cycle is cycle 1, so WAIT gives up on its
  // (CORE_TIMEOUT-1)th cycle and the flag shows CORE_TIMEOUT after start
  assign timeout = tcount == TW'(CORE_TIMEOUT - 2);
  assign ctr_max = ctr_r == '1;

  assign core_key      = key_r;
  assign core_nonce    = nonce_r;
  assign core_counter  = ctr_r;
  assign core_state_in = data_r;

  chacha20_byte_mask u_mask (
    .data   (core_state_out),
    .count  (bytes_r),
    .masked (masked)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (cfg_valid) state_nx = ST_ARMED;
      ST_ARMED: if (s_valid) state_nx = ST_KICK;
      ST_KICK:  if (!core_busy) state_nx = ST_WAIT;
      ST_WAIT: begin
        if (core_done)    state_nx = ST_EMIT;
        else if (timeout) state_nx = ST_ERR;
      end
      ST_EMIT: begin
        if (m_ready) begin
          if (last_r)       state_nx = ST_IDLE;
          else if (ctr_max) state_nx = ST_ERR;
          else              state_nx = ST_ARMED;
        end
      end
      ST_ERR:   if (err_clr) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready  = 1'b0;
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    core_start = 1'b0;
    busy       = 1'b1;
    unique case (state)
      ST_IDLE: begin
        cfg_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_ARMED: s_ready    = 1'b1;
      ST_KICK:  core_start = !core_busy;
      ST_WAIT:  ;
      ST_EMIT:  m_valid    = 1'b1;
      ST_ERR:   busy       = 1'b0;
      default:  busy       = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_r        <= '0;
      nonce_r      <= '0;
      ctr_r        <= '0;
      data_r       <= '0;
      bytes_r      <= '0;
      last_r       <= 1'b0;
      tcount       <= '0;
      m_data       <= '0;
      m_bytes      <= '0;
      m_last       <= 1'b0;
      blk_count    <= '0;
      err_ctr_wrap <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      if (state == ST_IDLE && cfg_valid) begin
        key_r     <= cfg_key;
        nonce_r   <= cfg_nonce;
        ctr_r     <= cfg_counter;
        blk_count <= '0;
      end
      if (state == ST_ARMED && s_valid) begin
        data_r  <= s_data;
        bytes_r <= clamp_bytes(s_bytes);
        last_r  <= s_last;
      end
      if (state == ST_KICK)      tcount <= '0;
      else if (state == ST_WAIT) tcount <= tcount + 1'b1;
      if (state == ST_WAIT && core_done) begin
        m_data  <= masked;
        m_bytes <= bytes_r;
        m_last  <= last_r;
      end
      if (state == ST_EMIT && m_ready) begin
        blk_count <= blk_count + 1'b1;
        if (!last_r && !ctr_max) ctr_r <= ctr_r + 1'b1;
      end
      if (err_clr) begin
        err_ctr_wrap <= 1'b0;
        err_timeout  <= 1'b0;
      end
      if (state == ST_WAIT && !core_done && timeout)
        err_timeout <= 1'b1;
      if (state == ST_EMIT && m_ready && !last_r && ctr_max)
        err_ctr_wrap <= 1'b1;
    end
  end

endmodule

// File: tb/tb_chacha20_stream_ctrl.sv
// Directed bench for chacha20_stream_ctrl with a behavioural
// ChaCha20 core checked against the published sunscreen vector.
module tb_chacha20_stream_ctrl;

  localparam int CORE_LAT = 15;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [255:0] cfg_key;
  logic [95:0]  cfg_nonce;
  logic [31:0]  cfg_counter;
  logic         err_clr;
  logic         s_valid;
  logic         s_ready;
  logic [511:0] s_data;
  logic [6:0]   s_bytes;
  logic         s_last;
  logic         m_valid;
  logic         m_ready;
  logic [511:0] m_data;
  logic [6:0]   m_bytes;
  logic         m_last;
  logic         core_start;
  logic         core_busy;
  logic         core_done;
  logic [255:0] core_key;
  logic [95:0]  core_nonce;
  logic [31:0]  core_counter;
  logic [511:0] core_state_in;
  logic [511:0] core_state_out;
  logic         busy;
  logic         err_ctr_wrap;
  logic         err_timeout;
  logic [31:0]  blk_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic core_hang;
  int   core_cnt;
  logic [511:0] core_res;

  localparam logic [255:0] KEY =
    256'h000102030405060708090a0b0c0d0e0f_101112131415161718191a1b1c1d1e1f;
  localparam logic [95:0] NONCE = 96'h000000000000004a00000000;

  string msg = {"Ladies and Gentlemen of the class of '99: ",
                "If I could offer you only one tip for the future, ",
                "sunscreen would be it."};

  logic [0:113][7:0] ct = {
    128'h6e2e359a2568f98041ba0728dd0d6981,
    128'he97e7aec1d4360c20a27afccfd9fae0b,
    128'hf91b65c5524733ab8f593dabcd62b357,
    128'h1639d624e65152ab8f530c359f0861d8,
    128'h07ca0dbf500d6a6156a38e088a22b65e,
    128'h52bc514d16ccf806818ce91ab7793736,
    128'h5af90bbf74a35be6b40b8eedf2785e42,
    16'h874d};

  chacha20_stream_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_key        (cfg_key),
    .cfg_nonce      (cfg_nonce),
    .cfg_counter    (cfg_counter),
    .err_clr        (err_clr),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .s_bytes        (s_bytes),
    .s_last         (s_last),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_bytes        (m_bytes),
    .m_last         (m_last),
    .core_start     (core_start),
    .core_busy      (core_busy),
    .core_done      (core_done),
    .core_key       (core_key),
    .core_nonce     (core_nonce),
    .core_counter   (core_counter),
    .core_state_in  (core_state_in),
    .core_state_out (core_state_out),
    .busy           (busy),
    .err_ctr_wrap   (err_ctr_wrap),
    .err_timeout    (err_timeout),
    .blk_count      (blk_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [15:0][31:0] qr(
    input logic [15:0][31:0] v,
    input int a, input int b, input int c, input int d
  );
    v[a] = v[a] + v[b]; v[d] = rotl(v[d] ^ v[a], 16);
    v[c] = v[c] + v[d]; v[b] = rotl(v[b] ^ v[c], 12);
    v[a] = v[a] + v[b]; v[d] = rotl(v[d] ^ v[a], 8);
    v[c] = v[c] + v[d]; v[b] = rotl(v[b] ^ v[c], 7);
    return v;
  endfunction

  function automatic logic [511:0] chacha_xor(
    input logic [255:0] k, input logic [95:0] n,
    input logic [31:0] c, input logic [511:0] p
  );
    logic [15:0][31:0] s;
    logic [15:0][31:0] x;
    logic [511:0] r;
    s[0] = 32'h61707865; s[1] = 32'h3320646e;
    s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = bswap(k[255-32*i -: 32]);
    s[12] = c;
    for (int i = 0; i < 3; i++) s[13+i] = bswap(n[95-32*i -: 32]);
    x = s;
    for (int i = 0; i < 10; i++) begin
      x = qr(x, 0, 4, 8, 12);  x = qr(x, 1, 5, 9, 13);
      x = qr(x, 2, 6, 10, 14); x = qr(x, 3, 7, 11, 15);
      x = qr(x, 0, 5, 10, 15); x = qr(x, 1, 6, 11, 12);
      x = qr(x, 2, 7, 8, 13);  x = qr(x, 3, 4, 9, 14);
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
    return p ^ r;
  endfunction

  // behavioural core: fixed latency, optional hang (no done)
  always @(posedge clk) begin
    core_done <= 1'b0;
    if (!rst_n) begin
      core_busy      <= 1'b0;
      core_cnt       <= 0;
      core_state_out <= '0;
      core_res       <= '0;
    end else if (core_start) begin
      core_busy <= 1'b1;
      core_cnt  <= CORE_LAT;
      core_res  <= chacha_xor(core_key, core_nonce, core_counter,
                              core_state_in);
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) begin
        core_busy <= 1'b0;
        if (!core_hang) begin
          core_done      <= 1'b1;
          core_state_out <= core_res;
        end
      end
    end
  end

  function automatic logic [511:0] pt_blk(input int base);
    logic [511:0] r;
    for (int k = 0; k < 64; k++)
      r[8*k +: 8] = (base + k < msg.len()) ? msg[base+k] : 8'hAA;
    return r;
  endfunction

  function automatic logic [511:0] ct_blk(input int base, input int n);
    logic [511:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[8*k +: 8] = ct[base+k];
    return r;
  endfunction

  task automatic check(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cfg(input logic [31:0] ctr);
    cfg_key     = KEY;
    cfg_nonce   = NONCE;
    cfg_counter = ctr;
    cfg_valid   = 1'b1;
    for (int i = 0; i < 100 && !cfg_ready; i++) @(negedge clk);
    check("cfg_ready", {511'b0, cfg_ready}, 512'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic send_blk(input logic [511:0] d, input logic [6:0] n,
                          input logic last);
    s_data  = d;
    s_bytes = n;
    s_last  = last;
    s_valid = 1'b1;
    for (int i = 0; i < 100 && !s_ready; i++) @(negedge clk);
    check("s_ready", {511'b0, s_ready}, 512'd1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    for (int i = 0; i < 200 && !m_valid; i++) @(negedge clk);
    check({tag, "_mvalid"}, {511'b0, m_valid}, 512'd1);
  endtask

  task automatic recv(input string tag, input logic [511:0] d,
                      input logic [6:0] n, input logic last);
    wait_out(tag);
    check({tag, "_data"}, m_data, d);
    check({tag, "_bytes"}, {505'b0, m_bytes}, {505'b0, n});
    check({tag, "_last"}, {511'b0, m_last}, {511'b0, last});
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_key = '0; cfg_nonce = '0;
    cfg_counter = '0; err_clr = 1'b0; s_valid = 1'b0; s_data = '0;
    s_bytes = '0; s_last = 1'b0; m_ready = 1'b0; core_hang = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_cfg_ready", {511'b0, cfg_ready}, 512'd1);
    check("rst_s_ready", {511'b0, s_ready}, 512'd0);
    check("rst_m_valid", {511'b0, m_valid}, 512'd0);
    check("rst_core_start", {511'b0, core_start}, 512'd0);
    check("rst_busy", {511'b0, busy}, 512'd0);
    check("rst_m_data", m_data, 512'd0);
    check("rst_core_key", {256'b0, core_key}, 512'd0);
    check("rst_blk_count", {480'b0, blk_count}, 512'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: published two-block vector, 64 + 50 bytes
    send_cfg(32'd1);
    check("t1_busy", {511'b0, busy}, 512'd1);
    send_blk(pt_blk(0), 7'd64, 1'b0);
    check("t1_core_start", {511'b0, core_start}, 512'd1);
    check("t1_counter1", {480'b0, core_counter}, 512'd1);
    recv("t1_b1", ct_blk(0, 64), 7'd64, 1'b0);
    send_blk(pt_blk(64), 7'd50, 1'b1);
    check("t1_counter2", {480'b0, core_counter}, 512'd2);
    recv("t1_b2", ct_blk(64, 50), 7'd50, 1'b1);
    check("t1_blk_count", {480'b0, blk_count}, 512'd2);
    check("t1_idle", {511'b0, cfg_ready}, 512'd1);

    // 2: counter at max with a second block pending
    send_cfg(32'hFFFF_FFFF);
    send_blk(pt_blk(0), 7'd64, 1'b0);
    wait_out("t2");
    check("t2_last", {511'b0, m_last}, 512'd0);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check("t2_wrap", {511'b0, err_ctr_wrap}, 512'd1);
    check("t2_busy", {511'b0, busy}, 512'd0);
    check("t2_cfg_ready", {511'b0, cfg_ready}, 512'd0);
    check("t2_blk_count", {480'b0, blk_count}, 512'd1);
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_s_ready", {511'b0, s_ready}, 512'd0);
    end
    s_valid = 1'b0;
    pulse_clr();
    check("t2_clr_idle", {511'b0, cfg_ready}, 512'd1);
    check("t2_clr_wrap", {511'b0, err_ctr_wrap}, 512'd0);

    // 3: core never finishes
    core_hang = 1'b1;
    send_cfg(32'd7);
    send_blk(pt_blk(0), 7'd64, 1'b1);
    check("t3_core_start", {511'b0, core_start}, 512'd1);
    for (int i = 1; i < 64; i++) @(negedge clk);
    check("t3_to_early", {511'b0, err_timeout}, 512'd0);
    check("t3_busy_early", {511'b0, busy}, 512'd1);
    @(negedge clk);
    check("t3_to_flag", {511'b0, err_timeout}, 512'd1);
    check("t3_err_busy", {511'b0, busy}, 512'd0);
    check("t3_err_cfg", {511'b0, cfg_ready}, 512'd0);
    pulse_clr();
    check("t3_clr_idle", {511'b0, cfg_ready}, 512'd1);
    check("t3_clr_to", {511'b0, err_timeout}, 512'd0);
    core_hang = 1'b0;
    repeat (20) @(negedge clk);

    // 4: output back-pressure for 20 cycles
    send_cfg(32'd1);
    send_blk(pt_blk(0), 7'd64, 1'b0);
    wait_out("t4");
    for (int i = 0; i < 20; i++) begin
      check("t4_hold_valid", {511'b0, m_valid}, 512'd1);
      check("t4_hold_data", m_data, ct_blk(0, 64));
      check("t4_hold_s_ready", {511'b0, s_ready}, 512'd0);
      check("t4_hold_start", {511'b0, core_start}, 512'd0);
      @(negedge clk);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    send_blk(pt_blk(64), 7'd50, 1'b1);
    recv("t4_b2", ct_blk(64, 50), 7'd50, 1'b1);

    // 5: reset while waiting on the core
    send_cfg(32'd1);
    send_blk(pt_blk(0), 7'd64, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_cfg_ready", {511'b0, cfg_ready}, 512'd1);
    check("t5_m_valid", {511'b0, m_valid}, 512'd0);
    check("t5_core_start", {511'b0, core_start}, 512'd0);
    check("t5_errs", {510'b0, err_ctr_wrap, err_timeout}, 512'd0);
    check("t5_blk_count", {480'b0, blk_count}, 512'd0);
    repeat (20) @(negedge clk);

    // 6: out-of-range byte counts mean a full block
    send_cfg(32'd1);
    send_blk(pt_blk(0), 7'd0, 1'b0);
    recv("t6_b0", ct_blk(0, 64), 7'd64, 1'b0);
    send_blk(pt_blk(64), 7'd100, 1'b1);
    recv("t6_b100", chacha_xor(KEY, NONCE, 32'd2, pt_blk(64)),
         7'd64, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
